// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator.
// Produces an oversample tick (os_tick) every divisor(+carry) clocks and a bit
// tick (baud_tick) on every OSR-th oversample tick, plus the oversample phase.
// Optional feature macro: BAUD_FRAC_EN adds the fractional accumulator; when it
// is undefined the frac port is ignored and every period is divisor_reg clocks.
module baud_gen_frac #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned FRAC_W    = 4,
    parameter int unsigned OSR       = 16,
    parameter int unsigned RESET_DIV = 651
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_divisor,
    input  logic [DIV_W-1:0]        divisor,
    input  logic [FRAC_W-1:0]       frac,
    output logic                    os_tick,
    output logic                    baud_tick,
    output logic [$clog2(OSR)-1:0]  os_phase,
    output logic                    active
);

    localparam int unsigned        PH_W        = $clog2(OSR);
    localparam logic [DIV_W-1:0]   ResetDivV   = DIV_W'(RESET_DIV);
    localparam logic [PH_W-1:0]    PhaseLast   = PH_W'(OSR - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [PH_W-1:0]  phase_q;
    logic             os_tick_q;
    logic             baud_tick_q;

    logic             run;
    logic             extra;       // one extra clock in the current period
    logic [DIV_W:0]   period_m1;   // P-1, one bit wider so 2^DIV_W-1 + 1 fits
    logic             period_end;

    assign run        = enable && (div_q != '0);
    assign period_m1  = {1'b0, div_q} + {{DIV_W{1'b0}}, extra} - (DIV_W+1)'(1);
    assign period_end = run && ({1'b0, cnt_q} == period_m1);

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] acc_q;
    logic              extra_q;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
    assign extra   = extra_q;

    // Fractional accumulator: its carry stretches the following period by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_q  <= '0;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else if (load_divisor) begin
            frac_q  <= frac;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else if (period_end) begin
            acc_q   <= acc_sum[FRAC_W-1:0];
            extra_q <= acc_sum[FRAC_W];
        end
    end
`else
    logic unused_frac;

    assign extra       = 1'b0;
    assign unused_frac = ^frac;
`endif

    // Divisor register, period counter, oversample phase and registered ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= ResetDivV;
            cnt_q       <= '0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
        end else if (load_divisor) begin
            // Abandon the current bit: restart counting, suppress any tick.
            div_q       <= divisor;
            cnt_q       <= '0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            os_tick_q   <= period_end;
            baud_tick_q <= period_end && (phase_q == PhaseLast);
            if (period_end) begin
                cnt_q   <= '0;
                phase_q <= (phase_q == PhaseLast) ? '0 : phase_q + PH_W'(1);
            end else if (run) begin
                cnt_q   <= cnt_q + DIV_W'(1);
            end
        end
    end

    assign os_tick   = os_tick_q;
    assign baud_tick = baud_tick_q;
    assign os_phase  = phase_q;
    assign active    = run;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac (default parameters).
// Expected tick positions are pushed to queues before each run and popped as
// the DUT emits ticks; leftovers or unexpected ticks are failures.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load_divisor;
    logic [15:0] divisor;
    logic [3:0]  frac;
    logic        os_tick;
    logic        baud_tick;
    logic [3:0]  os_phase;
    logic        active;

    int errors = 0;
    int checks = 0;
    int exp_os[$];
    int exp_ph[$];
    int exp_bd[$];
    int e;
    int ep;

`ifdef BAUD_FRAC_EN
    localparam bit FracOn = 1'b1;
    localparam int Baud1  = 71;
`else
    localparam bit FracOn = 1'b0;
    localparam int Baud1  = 64;
`endif

    baud_gen_frac dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load_divisor (load_divisor),
        .divisor      (divisor),
        .frac         (frac),
        .os_tick      (os_tick),
        .baud_tick    (baud_tick),
        .os_phase     (os_phase),
        .active       (active)
    );

    always #5 clk = ~clk;

    // Stimulus only: one-cycle load strobe; returns 1 time unit after the load edge.
    task automatic do_load(input int d, input int f);
        divisor      = 16'(d);
        frac         = 4'(f);
        load_divisor = 1'b1;
        @(posedge clk); #1;
        load_divisor = 1'b0;
    endtask

    // Stimulus only: os ticks every p clocks, baud on each 16th.
    task automatic push_fixed(input int p, input int n);
        for (int k = 1; k <= n; k++) begin
            exp_os.push_back(p * k);
            exp_ph.push_back(k % 16);
            if (k % 16 == 0) exp_bd.push_back(p * k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load_divisor = 1'b0; divisor = '0; frac = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (os_tick !== 1'b0 || baud_tick !== 1'b0 || os_phase !== 4'd0 || active !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: os=%b baud=%b phase=%0d active=%b, want 0 0 0 1",
                     os_tick, baud_tick, os_phase, active);
        end
        push_fixed(651, 16);
        rst = 1'b0;
        for (int s = 1; s <= 10420; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                if (exp_os.size() == 0) begin
                    errors++; $display("FAIL reset_os: unexpected os_tick at %0d", s);
                end else begin
                    e = exp_os.pop_front(); ep = exp_ph.pop_front();
                    if (s !== e || int'(os_phase) !== ep) begin
                        errors++;
                        $display("FAIL reset_os: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                    end
                end
            end
            if (baud_tick) begin
                checks++;
                e = (exp_bd.size() == 0) ? -1 : exp_bd.pop_front();
                if (s !== e || os_phase !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_baud: at %0d phase %0d, want %0d phase 0", s, os_phase, e);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0 || exp_bd.size() != 0) begin
            errors++;
            $display("FAIL reset_missing: os left %0d baud left %0d, want 0 0", exp_os.size(), exp_bd.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_div4();
        do_load(4, 0);
        checks++;
        if (os_tick !== 1'b0 || baud_tick !== 1'b0 || os_phase !== 4'd0) begin
            errors++;
            $display("FAIL div4_load: os=%b baud=%b phase=%0d, want 0 0 0", os_tick, baud_tick, os_phase);
        end
        push_fixed(4, 32);
        for (int s = 1; s <= 130; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep) begin
                    errors++;
                    $display("FAIL div4_os: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                end
            end
            if (baud_tick) begin
                checks++;
                e = (exp_bd.size() == 0) ? -1 : exp_bd.pop_front();
                if (s !== e || os_phase !== 4'd0) begin
                    errors++;
                    $display("FAIL div4_baud: at %0d phase %0d, want %0d phase 0", s, os_phase, e);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0 || exp_bd.size() != 0) begin
            errors++;
            $display("FAIL div4_missing: os left %0d baud left %0d, want 0 0", exp_os.size(), exp_bd.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_frac();
        int t = 0;
        int acc = 0;
        int carry = 0;
        int sum;
        for (int k = 1; k <= 32; k++) begin
            t += 4 + carry;
            exp_os.push_back(t);
            exp_ph.push_back(k % 16);
            if (k == 16) exp_bd.push_back(Baud1);
            if (k == 32) exp_bd.push_back(t);
            sum   = acc + (FracOn ? 8 : 0);
            carry = sum / 16;
            acc   = sum % 16;
        end
        do_load(4, 8);
        for (int s = 1; s <= t + 2; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep) begin
                    errors++;
                    $display("FAIL frac_os: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                end
            end
            if (baud_tick) begin
                checks++;
                e = (exp_bd.size() == 0) ? -1 : exp_bd.pop_front();
                if (s !== e) begin
                    errors++;
                    $display("FAIL frac_baud: at %0d, want %0d", s, e);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0 || exp_bd.size() != 0) begin
            errors++;
            $display("FAIL frac_missing: os left %0d baud left %0d, want 0 0", exp_os.size(), exp_bd.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_div_zero();
        do_load(0, 0);
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL div0_active: got %b, want 0", active);
        end
        for (int s = 1; s <= 1000; s++) begin
            @(posedge clk); #1;
            if (os_tick || baud_tick) begin
                checks++; errors++;
                $display("FAIL div0_tick: os=%b baud=%b at %0d, want 0 0", os_tick, baud_tick, s);
            end
        end
        checks++;
        if (os_phase !== 4'd0 || active !== 1'b0) begin
            errors++; $display("FAIL div0_hold: phase=%0d active=%b, want 0 0", os_phase, active);
        end
        do_load(2, 0);
        push_fixed(2, 3);
        for (int s = 1; s <= 6; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep) begin
                    errors++;
                    $display("FAIL div2_os: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0) begin
            errors++; $display("FAIL div2_missing: os left %0d, want 0", exp_os.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_enable();
        do_load(4, 0);
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            @(posedge clk); #1;
            checks++;
            if (os_tick !== 1'b0 || baud_tick !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL enable_low: os=%b baud=%b active=%b at %0d, want 0 0 0",
                         os_tick, baud_tick, active, s);
            end
        end
        enable = 1'b1;
        exp_os.push_back(2); exp_ph.push_back(1);
        exp_os.push_back(6); exp_ph.push_back(2);
        for (int s = 1; s <= 8; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep) begin
                    errors++;
                    $display("FAIL enable_resume: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0) begin
            errors++; $display("FAIL enable_missing: os left %0d, want 0", exp_os.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_load_mid();
        do_load(8, 0);
        push_fixed(8, 15);
        // 15 periods put os_phase at 15, then 3 more clocks reach count 3.
        for (int s = 1; s <= 123; s++) begin
            @(posedge clk); #1;
            if (os_tick || baud_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep || baud_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_pre: at %0d phase %0d baud %b, want %0d phase %0d baud 0",
                             s, os_phase, baud_tick, e, ep);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0 || os_phase !== 4'd15) begin
            errors++;
            $display("FAIL mid_setup: os left %0d phase %0d, want 0 15", exp_os.size(), os_phase);
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
        do_load(8, 0);
        checks++;
        if (os_tick !== 1'b0 || baud_tick !== 1'b0 || os_phase !== 4'd0) begin
            errors++;
            $display("FAIL mid_load: os=%b baud=%b phase=%0d, want 0 0 0", os_tick, baud_tick, os_phase);
        end
        push_fixed(8, 16);
        for (int s = 1; s <= 130; s++) begin
            @(posedge clk); #1;
            if (os_tick) begin
                checks++;
                e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
                ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
                if (s !== e || int'(os_phase) !== ep) begin
                    errors++;
                    $display("FAIL mid_os: at %0d phase %0d, want %0d phase %0d", s, os_phase, e, ep);
                end
            end
            if (baud_tick) begin
                checks++;
                e = (exp_bd.size() == 0) ? -1 : exp_bd.pop_front();
                if (s !== e) begin
                    errors++; $display("FAIL mid_baud: at %0d, want %0d", s, e);
                end
            end
        end
        checks++;
        if (exp_os.size() != 0 || exp_bd.size() != 0) begin
            errors++;
            $display("FAIL mid_missing: os left %0d baud left %0d, want 0 0", exp_os.size(), exp_bd.size());
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_div1();
        do_load(1, 0);
        push_fixed(1, 20);
        for (int s = 1; s <= 20; s++) begin
            @(posedge clk); #1;
            checks++;
            e  = (exp_os.size() == 0) ? -1 : exp_os.pop_front();
            ep = (exp_ph.size() == 0) ? -1 : exp_ph.pop_front();
            if (os_tick !== 1'b1 || s !== e || int'(os_phase) !== ep) begin
                errors++;
                $display("FAIL div1_os: os=%b phase %0d at %0d, want 1 phase %0d", os_tick, os_phase, s, ep);
            end
            checks++;
            if (baud_tick !== (s == 16)) begin
                errors++; $display("FAIL div1_baud: got %b at %0d, want %b", baud_tick, s, s == 16);
            end
        end
        exp_os.delete(); exp_ph.delete(); exp_bd.delete();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!os_tick && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!os_tick) begin
            errors++; $display("FAIL rstmid_wait: os_tick 0 after %0d cycles, want 1", n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (os_tick !== 1'b0 || baud_tick !== 1'b0 || os_phase !== 4'd0 || active !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: os=%b baud=%b phase=%0d active=%b, want 0 0 0 1",
                     os_tick, baud_tick, os_phase, active);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div4();
        test_frac();
        test_div_zero();
        test_enable();
        test_load_mid();
        test_div1();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
